// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction fetch address, imem handshake, one-entry hold buffer and IF/ID register.
module if_fetch_unit #(
  parameter int ADDR_W = 32,
  parameter int INSTR_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pc_freeze,
  input  logic               IF_ID_freeze,
  input  logic               IF_ID_flush,
  input  logic               take_branch,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] IF_ID_instr,
  output logic [ADDR_W-1:0]  IF_ID_pc_plus4,
  output logic               IF_ID_valid
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d, redir_addr_q, redir_addr_d, hold_pc4_q, hold_pc4_d;
  logic [ADDR_W-1:0] id_pc4_q, id_pc4_d, ld_pc4, addr_p4;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_d, id_instr_q, id_instr_d, ld_instr;
  logic redirect_pending_q, redirect_pending_d, id_valid_q, id_valid_d;
  logic br, fl, load;
  assign br = take_branch & ~pc_freeze;
  assign fl = IF_ID_flush & ~IF_ID_freeze;
  assign addr_p4 = fetch_addr_q + ADDR_W'(4);
  always_comb begin
    state_d = state_q;
    fetch_addr_d = fetch_addr_q;
    redirect_pending_d = redirect_pending_q;
    redir_addr_d = redir_addr_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d = hold_pc4_q;
    load = 1'b0;
    ld_instr = hold_instr_q;
    ld_pc4 = hold_pc4_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH:
        if (imem_ready) begin
          if (br) begin
            fetch_addr_d = branch_target;
            redirect_pending_d = 1'b0;
          end else if (redirect_pending_q) begin
            fetch_addr_d = redir_addr_q;
            redirect_pending_d = 1'b0;
          end else if (fl) begin
            fetch_addr_d = addr_p4;
          end else if (IF_ID_freeze) begin
            hold_instr_d = imem_rdata;
            hold_pc4_d = addr_p4;
            fetch_addr_d = addr_p4;
            state_d = HOLD;
          end else begin
            load = 1'b1;
            ld_instr = imem_rdata;
            ld_pc4 = addr_p4;
            fetch_addr_d = addr_p4;
          end
        end else if (br) begin
          redirect_pending_d = 1'b1;
          redir_addr_d = branch_target;
        end
      HOLD:
        if (br) begin
          fetch_addr_d = branch_target;
          state_d = FETCH;
        end else if (!IF_ID_freeze) begin
          load = ~fl;
          state_d = FETCH;
        end
      default: state_d = IDLE;
    endcase
    // load never coincides with freeze or flush, so freeze > flush > load > bubble reduces to this
    id_instr_d = IF_ID_freeze ? id_instr_q : load ? ld_instr : '0;
    id_pc4_d = IF_ID_freeze ? id_pc4_q : load ? ld_pc4 : '0;
    id_valid_d = IF_ID_freeze ? id_valid_q : load;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fetch_addr_q <= RESET_PC;
      redirect_pending_q <= 1'b0;
      redir_addr_q <= '0;
      hold_instr_q <= '0;
      hold_pc4_q <= '0;
      id_instr_q <= '0;
      id_pc4_q <= '0;
      id_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fetch_addr_q <= fetch_addr_d;
      redirect_pending_q <= redirect_pending_d;
      redir_addr_q <= redir_addr_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q <= hold_pc4_d;
      id_instr_q <= id_instr_d;
      id_pc4_q <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end
  assign imem_req = (state_q == FETCH);
  assign imem_addr = fetch_addr_q;
  assign IF_ID_instr = id_instr_q;
  assign IF_ID_pc_plus4 = id_pc4_q;
  assign IF_ID_valid = id_valid_q;
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: directed and random fetch scenarios checked against a queue-based reference model.
module tb_if_fetch_unit;
  logic clk, rst_n, pc_freeze, IF_ID_freeze, IF_ID_flush, take_branch, imem_ready;
  logic [31:0] branch_target, imem_rdata, imem_addr, IF_ID_instr, IF_ID_pc_plus4;
  logic imem_req, IF_ID_valid;
  logic w_req, w_valid;
  logic [31:0] w_addr, w_instr, w_pc4;
  int tests = 0, fails = 0;
  logic m_req, m_valid;
  logic [31:0] m_addr, m_instr, m_pc4;
  logic [31:0] pend_q[$];
  logic [63:0] hold_q[$];

  if_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .pc_freeze(pc_freeze), .IF_ID_freeze(IF_ID_freeze),
    .IF_ID_flush(IF_ID_flush), .take_branch(take_branch), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IF_ID_instr(IF_ID_instr), .IF_ID_pc_plus4(IF_ID_pc_plus4), .IF_ID_valid(IF_ID_valid));

  if_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n), .pc_freeze(1'b0), .IF_ID_freeze(1'b0),
    .IF_ID_flush(1'b0), .take_branch(1'b0), .branch_target(32'h0),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(1'b1), .imem_rdata(32'hA5),
    .IF_ID_instr(w_instr), .IF_ID_pc_plus4(w_pc4), .IF_ID_valid(w_valid));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit r, input bit frz, input bit fls, input bit tb, input logic [31:0] tgt);
    imem_ready = r;
    pc_freeze = frz;
    IF_ID_freeze = frz;
    IF_ID_flush = fls;
    take_branch = tb;
    branch_target = tgt;
    imem_rdata = m_addr;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 32'h100);
    chk("rst_valid", IF_ID_valid, 0);
    chk("rst_instr", IF_ID_instr, 0);
    chk("rst_pc4", IF_ID_pc_plus4, 0);
    chk("rst_waddr", w_addr, 32'hFFFF_FFFC);
    m_req = 1'b0;
    m_addr = 32'h100;
    m_instr = '0;
    m_pc4 = '0;
    m_valid = 1'b0;
    pend_q.delete();
    hold_q.delete();
    rst_n = 1'b1;
  endtask

  // Model: idle = no request and nothing held; holding = a word parked in hold_q.
  task automatic step();
    logic br, fl, dl;
    logic [31:0] a4, di, dp;
    br = take_branch & ~pc_freeze;
    fl = IF_ID_flush & ~IF_ID_freeze;
    dl = 1'b0;
    di = '0;
    dp = '0;
    a4 = m_addr + 32'd4;
    if (!m_req && hold_q.size() == 0) m_req = 1'b1;
    else if (m_req) begin
      if (imem_ready) begin
        if (br) begin m_addr = branch_target; pend_q.delete(); end
        else if (pend_q.size() != 0) m_addr = pend_q.pop_front();
        else if (fl) m_addr = a4;
        else if (IF_ID_freeze) begin hold_q.push_back({imem_rdata, a4}); m_addr = a4; m_req = 1'b0; end
        else begin dl = 1'b1; di = imem_rdata; dp = a4; m_addr = a4; end
      end else if (br) begin
        pend_q.delete();
        pend_q.push_back(branch_target);
      end
    end else begin
      if (br) begin hold_q.delete(); m_addr = branch_target; m_req = 1'b1; end
      else if (!IF_ID_freeze) begin
        if (!fl) begin dl = 1'b1; {di, dp} = hold_q[0]; end
        hold_q.delete();
        m_req = 1'b1;
      end
    end
    if (!IF_ID_freeze) begin
      m_valid = dl;
      m_instr = dl ? di : '0;
      m_pc4 = dl ? dp : '0;
    end
    @(posedge clk);
    #1;
    chk("req", imem_req, m_req);
    if (m_req) chk("addr", imem_addr, m_addr);
    chk("valid", IF_ID_valid, m_valid);
    chk("instr", IF_ID_instr, m_instr);
    chk("pc4", IF_ID_pc_plus4, m_pc4);
  endtask

  initial begin
    rst_n = 1'b1;
    m_addr = 32'h100;
    drive(1, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    do_reset();
    chk("idle_req", imem_req, 0);
    chk("w_idle_req", w_req, 0);
    step();
    chk("first_addr", imem_addr, 32'h100);
    chk("w_first", w_addr, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0, 0); step();
    chk("stream0", IF_ID_instr, 32'h100);
    chk("w_wrap_addr", w_addr, 32'h0);
    chk("w_wrap_pc4", w_pc4, 32'h0);
    drive(1, 0, 0, 0, 0); step();
    chk("stream1", IF_ID_instr, 32'h104);
    for (int i = 0; i < 3; i++) begin drive(1, 1, 0, 0, 0); step(); end
    chk("hold_keeps", IF_ID_instr, 32'h104);
    chk("hold_noreq", imem_req, 0);
    drive(1, 0, 0, 0, 0); step();
    chk("release_instr", IF_ID_instr, 32'h108);
    chk("release_addr", imem_addr, 32'h10C);
    drive(1, 0, 0, 0, 0); step();
    drive(1, 0, 1, 1, 32'h200); step();
    chk("br_bubble", IF_ID_valid, 0);
    chk("br_addr", imem_addr, 32'h200);
    drive(1, 0, 0, 1, 32'h120); step();
    drive(0, 0, 0, 1, 32'h300); step();
    drive(0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0); step();
    chk("wait_addr", imem_addr, 32'h120);
    drive(1, 0, 0, 0, 0); step();
    chk("late_redir", imem_addr, 32'h300);
    chk("late_discard", IF_ID_valid, 0);
    drive(0, 0, 0, 0, 0); step();
    imem_ready = 1'b0; pc_freeze = 1'b1; take_branch = 1'b1; branch_target = 32'h400; step();
    drive(1, 0, 0, 0, 0); step();
    chk("frz_nobr", imem_addr, 32'h304);
    drive(1, 1, 0, 0, 0); step();
    drive(1, 1, 0, 0, 0); step();
    do_reset();
    drive(1, 0, 0, 0, 0); step();
    for (int i = 0; i < 600; i++) begin
      imem_ready = ($urandom_range(3) != 0);
      pc_freeze = ($urandom_range(6) == 0);
      IF_ID_freeze = ($urandom_range(6) == 0);
      IF_ID_flush = ($urandom_range(9) == 0);
      take_branch = ($urandom_range(6) == 0);
      branch_target = {$urandom_range(32'h3FFF_FFFF), 2'b00};
      imem_rdata = $urandom;
      if ($urandom_range(99) == 0) do_reset();
      step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
